// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Forward-select encodings and the scoreboard entry layout.
package hazard_pkg;

  // Widest register address a scoreboard entry can hold.
  // Narrower register files are zero-extended into it.
  localparam int SB_AW = 8;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [SB_AW-1:0] rd;
    logic             is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  // True when the in-flight entry produces the register ID reads.
  function automatic logic sb_hit(
    input sb_entry_t        e,
    input logic [SB_AW-1:0] src,
    input logic             src_used,
    input logic             zero_reg
  );
    return e.valid && e.wr_en && src_used &&
           (e.rd == src) &&
           !(zero_reg && (src == '0));
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forward select for one ALU source.
// Nearest producer (EX) wins over MEM; WB never forwards.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int ZERO_REG = 1
) (
  input  logic [SB_AW-1:0] src,
  input  logic             src_used,
  input  sb_entry_t        ex_e,
  input  sb_entry_t        mem_e,
  output logic [1:0]       sel,
  output logic             ex_hit
);

  logic mem_hit;
  logic unused_ld;

  assign unused_ld = ex_e.is_load ^ mem_e.is_load;

  // Priority compare against the two forwarding stages.
  always_comb begin
    ex_hit  = sb_hit(ex_e, src, src_used, ZERO_REG != 0);
    mem_hit = sb_hit(mem_e, src, src_used, ZERO_REG != 0);
    sel     = FWD_REG;
    unique case (1'b1)
      ex_hit:  sel = FWD_EXMEM;
      mem_hit: sel = FWD_MEMWB;
      default: sel = FWD_REG;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: scoreboard of EX/MEM/WB writers,
// load-use stall, branch/jump flush, memory freeze and forwarding.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_reg,
  input  logic              id_is_load,
  input  logic              id_jump,
  input  logic              ex_branch_taken,
  input  logic              dmem_busy,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  sb_entry_t ex_q, ex_d;
  sb_entry_t mem_q, mem_d;
  sb_entry_t wb_q, wb_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [SB_AW-1:0] rs_x, rt_x;
  logic [1:0]       sel_a, sel_b;
  logic             ex_hit_a, ex_hit_b;
  logic             load_use, mem_wait;
  logic             unused_wb;

  assign rs_x = SB_AW'(id_rs);
  assign rt_x = SB_AW'(id_rt);

  // WB is tracked for visibility only; the regfile bypasses it.
  assign unused_wb = ^wb_q;

  hazard_fwd_sel #(.ZERO_REG(ZERO_REG)) u_fwd_a (
    .src      (rs_x),
    .src_used (id_use_rs),
    .ex_e     (ex_q),
    .mem_e    (mem_q),
    .sel      (sel_a),
    .ex_hit   (ex_hit_a)
  );

  hazard_fwd_sel #(.ZERO_REG(ZERO_REG)) u_fwd_b (
    .src      (rt_x),
    .src_used (id_use_rt),
    .ex_e     (ex_q),
    .mem_e    (mem_q),
    .sel      (sel_b),
    .ex_hit   (ex_hit_b)
  );

  assign mem_wait = mem_q.valid & dmem_busy;
  assign load_use = id_valid & ex_q.is_load &
                    (ex_hit_a | ex_hit_b);

  // Control priority: freeze > branch > load-use > jump.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    freeze      = 1'b0;
    fwd_a       = FWD_REG;
    fwd_b       = FWD_REG;
    if (!rst) begin
      fwd_a = sel_a;
      fwd_b = sel_b;
      if (mem_wait) begin
        freeze = 1'b1;
      end else if (ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end else if (id_jump && id_valid) begin
        ifid_flush = 1'b1;
      end
    end
  end

  // Scoreboard shift; holds while memory stalls MEM.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!mem_wait) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = SB_EMPTY;
      if (id_valid && !idex_bubble) begin
        ex_d.valid   = 1'b1;
        ex_d.wr_en   = id_wr_en;
        ex_d.rd      = SB_AW'(id_wr_reg);
        ex_d.is_load = id_is_load;
      end
    end
  end

  // Saturating count of PC-stall cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= SB_EMPTY;
      mem_q       <= SB_EMPTY;
      wb_q        <= SB_EMPTY;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl.
// Each task drives one scenario and checks inline.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_rs;
  logic [3:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_wr_en;
  logic [3:0]  id_wr_reg;
  logic        id_is_load;
  logic        id_jump;
  logic        ex_branch_taken;
  logic        dmem_busy;
  logic        pc_stall;
  logic        ifid_stall;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        freeze;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_cnt;

  int checks = 0;
  int passed = 0;

  hazard_ctrl #(.REG_AW(4), .ZERO_REG(1), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_wr_en        (id_wr_en),
    .id_wr_reg       (id_wr_reg),
    .id_is_load      (id_is_load),
    .id_jump         (id_jump),
    .ex_branch_taken (ex_branch_taken),
    .dmem_busy       (dmem_busy),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .idex_bubble     (idex_bubble),
    .ifid_flush      (ifid_flush),
    .freeze          (freeze),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(
    input logic       v,
    input logic [3:0] rs,
    input logic       urs,
    input logic [3:0] rt,
    input logic       urt,
    input logic       we,
    input logic [3:0] wr,
    input logic       ld,
    input logic       jmp
  );
    id_valid   = v;
    id_rs      = rs;
    id_use_rs  = urs;
    id_rt      = rt;
    id_use_rt  = urt;
    id_wr_en   = we;
    id_wr_reg  = wr;
    id_is_load = ld;
    id_jump    = jmp;
    #1;
  endtask

  task automatic idle(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_branch_taken = 1'b0;
    dmem_busy       = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset_init();
    rst = 1'b1;
    ex_branch_taken = 1'b0;
    dmem_busy = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if ({pc_stall, ifid_stall, idex_bubble, ifid_flush, freeze} !== 5'b0)
      $display("FAIL rst_ctl got %b want 00000",
               {pc_stall, ifid_stall, idex_bubble, ifid_flush, freeze});
    else passed++;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0)
      $display("FAIL rst_fwd got %b want 0000", {fwd_a, fwd_b});
    else passed++;
    checks++;
    if (stall_cnt !== 16'd0)
      $display("FAIL rst_cnt got %0d want 0", stall_cnt);
    else passed++;
    step();
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_alu_fwd();
    set_id(1, 0, 0, 0, 0, 1, 3, 0, 0);
    step();
    set_id(1, 3, 1, 4, 1, 1, 6, 0, 0);
    checks++;
    if (fwd_a !== 2'b01)
      $display("FAIL alu_ex_fwd_a got %b want 01", fwd_a);
    else passed++;
    checks++;
    if (fwd_b !== 2'b00)
      $display("FAIL alu_unrel_fwd_b got %b want 00", fwd_b);
    else passed++;
    checks++;
    if (pc_stall !== 1'b0)
      $display("FAIL alu_no_stall got %b want 0", pc_stall);
    else passed++;
    step();
    set_id(1, 3, 1, 6, 1, 1, 0, 0, 0);
    checks++;
    if (fwd_a !== 2'b10)
      $display("FAIL alu_mem_fwd_a got %b want 10", fwd_a);
    else passed++;
    checks++;
    if (fwd_b !== 2'b01)
      $display("FAIL alu_ex_fwd_b got %b want 01", fwd_b);
    else passed++;
    step();
    set_id(1, 0, 1, 6, 0, 0, 0, 0, 0);
    checks++;
    if (fwd_a !== 2'b00)
      $display("FAIL alu_r0_fwd_a got %b want 00", fwd_a);
    else passed++;
    checks++;
    if (fwd_b !== 2'b00)
      $display("FAIL alu_unused_rt got %b want 00", fwd_b);
    else passed++;
    step();
    set_id(1, 6, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (fwd_a !== 2'b00)
      $display("FAIL alu_wb_nofwd got %b want 00", fwd_a);
    else passed++;
    idle(3);
  endtask

  task automatic test_load_use();
    set_id(1, 0, 0, 0, 0, 1, 5, 1, 0);
    checks++;
    if (pc_stall !== 1'b0)
      $display("FAIL lu_pre_stall got %b want 0", pc_stall);
    else passed++;
    step();
    set_id(1, 1, 1, 5, 1, 1, 8, 0, 0);
    checks++;
    if ({pc_stall, ifid_stall, idex_bubble, ifid_flush} !== 4'b1110)
      $display("FAIL lu_stall got %b want 1110",
               {pc_stall, ifid_stall, idex_bubble, ifid_flush});
    else passed++;
    step();
    checks++;
    if ({pc_stall, ifid_stall, idex_bubble} !== 3'b000)
      $display("FAIL lu_release got %b want 000",
               {pc_stall, ifid_stall, idex_bubble});
    else passed++;
    checks++;
    if (fwd_b !== 2'b10)
      $display("FAIL lu_fwd_b got %b want 10", fwd_b);
    else passed++;
    checks++;
    if (stall_cnt !== 16'd1)
      $display("FAIL lu_cnt got %0d want 1", stall_cnt);
    else passed++;
    idle(3);
  endtask

  task automatic test_branch_over_stall();
    set_id(1, 0, 0, 0, 0, 1, 7, 1, 0);
    step();
    set_id(1, 7, 1, 0, 0, 1, 9, 0, 0);
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if ({pc_stall, ifid_stall, idex_bubble, ifid_flush} !== 4'b0011)
      $display("FAIL br_ctl got %b want 0011",
               {pc_stall, ifid_stall, idex_bubble, ifid_flush});
    else passed++;
    step();
    ex_branch_taken = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 16'd1)
      $display("FAIL br_cnt got %0d want 1", stall_cnt);
    else passed++;
    checks++;
    if ({pc_stall, fwd_a} !== 3'b010)
      $display("FAIL br_after got %b want 010", {pc_stall, fwd_a});
    else passed++;
    idle(3);
  endtask

  task automatic test_jump();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if ({ifid_flush, idex_bubble, pc_stall} !== 3'b100)
      $display("FAIL jmp_flush got %b want 100",
               {ifid_flush, idex_bubble, pc_stall});
    else passed++;
    step();
    set_id(1, 2, 1, 0, 0, 1, 2, 0, 0);
    checks++;
    if (ifid_flush !== 1'b0)
      $display("FAIL jmp_one_cycle got %b want 0", ifid_flush);
    else passed++;
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (ifid_flush !== 1'b0)
      $display("FAIL jmp_invalid got %b want 0", ifid_flush);
    else passed++;
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if ({ifid_flush, idex_bubble} !== 2'b11)
      $display("FAIL jmp_vs_br got %b want 11", {ifid_flush, idex_bubble});
    else passed++;
    idle(3);
  endtask

  task automatic test_mem_wait();
    set_id(1, 0, 0, 0, 0, 1, 2, 0, 0);
    step();
    set_id(1, 0, 0, 0, 0, 1, 9, 1, 0);
    step();
    set_id(1, 9, 1, 2, 1, 1, 10, 0, 0);
    dmem_busy = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({freeze, pc_stall, idex_bubble, ifid_flush} !== 4'b1000)
        $display("FAIL mw_freeze_c%0d got %b want 1000", c,
                 {freeze, pc_stall, idex_bubble, ifid_flush});
      else passed++;
      checks++;
      if ({fwd_a, fwd_b} !== 4'b0110)
        $display("FAIL mw_hold_c%0d got %b want 0110", c, {fwd_a, fwd_b});
      else passed++;
      step();
    end
    dmem_busy = 1'b0;
    #1;
    checks++;
    if ({freeze, pc_stall, ifid_stall, idex_bubble} !== 4'b0111)
      $display("FAIL mw_deferred got %b want 0111",
               {freeze, pc_stall, ifid_stall, idex_bubble});
    else passed++;
    checks++;
    if (stall_cnt !== 16'd1)
      $display("FAIL mw_cnt_frozen got %0d want 1", stall_cnt);
    else passed++;
    step();
    checks++;
    if ({pc_stall, fwd_a, fwd_b} !== 5'b01000)
      $display("FAIL mw_after got %b want 01000", {pc_stall, fwd_a, fwd_b});
    else passed++;
    checks++;
    if (stall_cnt !== 16'd2)
      $display("FAIL mw_cnt got %0d want 2", stall_cnt);
    else passed++;
    idle(3);
  endtask

  task automatic test_reset_mid();
    set_id(1, 0, 0, 0, 0, 1, 1, 0, 0);
    step();
    set_id(1, 0, 0, 0, 0, 1, 2, 0, 0);
    step();
    set_id(1, 0, 0, 0, 0, 1, 3, 1, 0);
    step();
    set_id(1, 3, 1, 2, 1, 0, 0, 0, 1);
    checks++;
    if ({pc_stall, fwd_b} !== 3'b110)
      $display("FAIL rm_pre got %b want 110", {pc_stall, fwd_b});
    else passed++;
    dmem_busy = 1'b1;
    #1;
    checks++;
    if (freeze !== 1'b1)
      $display("FAIL rm_pre_freeze got %b want 1", freeze);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({pc_stall, ifid_stall, idex_bubble, ifid_flush, freeze,
         fwd_a, fwd_b} !== 9'b0)
      $display("FAIL rm_out got %b want 000000000",
               {pc_stall, ifid_stall, idex_bubble, ifid_flush, freeze,
                fwd_a, fwd_b});
    else passed++;
    checks++;
    if (stall_cnt !== 16'd0)
      $display("FAIL rm_cnt got %0d want 0", stall_cnt);
    else passed++;
    step();
    rst = 1'b0;
    id_jump = 1'b0;
    #1;
    checks++;
    if ({freeze, pc_stall, fwd_a, fwd_b} !== 6'b0)
      $display("FAIL rm_release got %b want 000000",
               {freeze, pc_stall, fwd_a, fwd_b});
    else passed++;
    idle(2);
  endtask

  initial begin
    test_reset_init();
    test_alu_fwd();
    test_load_use();
    test_branch_over_stall();
    test_jump();
    test_mem_wait();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
